jamma_input_scanner: RTL and testbench
======================================

Name: jamma_input_scanner

Overview:
- Parametrised time-multiplexed JAMMA control scanner for arcade cores; generalises the fixed two-player JSELECT toggle splitter.
- Drives an N-player select bus and waits a programmable settle time before sampling the shared 8-bit JAMMA input bus.
- Debounces each player's word and optionally ANDs the board's local joystick into player 0.
- Sits in each core's top level between the JAMMA connector pins and the core's I_JOYSTICK/I_PLAYER inputs.

Parameters:
- NUM_PLAYERS, 2: number of multiplexed player slots; legal range 1..8.
- JOY_W, 8: width of one player word. Active-low. Bit 7 is start, bits 5..0 are directions/fire.
- SEL_W, 1: width of jselect_o; must be ≥ clog2(NUM_PLAYERS), minimum 1.
- SETTLE_CYCLES, 4: clocks to wait after a select change before sampling; 0 allowed.
- DEBOUNCE_SAMPLES, 3: consecutive identical samples of a slot required before its output word updates; 1 means no debounce.
- LOCAL_MERGE, 1: when 1, player 0 sample = jjoy_i AND local_joy_i.

Ports:
- clk, input, 1: core pixel clock; all state on rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable_i, input, 1: scan enable; low freezes all state.
- jjoy_i, input, JOY_W: raw JAMMA bus, active-low. Already synchronised by the top level.
- local_joy_i, input, JOY_W: local DB9 joystick, active-low; unused bits are tied high.
- jselect_o, output, SEL_W: binary select of the player currently presented on jjoy_i.
- joy_o, output, NUM_PLAYERS*JOY_W: debounced words; player p occupies [p*JOY_W +: JOY_W].
- frame_o, output, 1: one-clock pulse when the last slot has been sampled (scan complete).

Behaviour:
- Reset values:
  - jselect_o = 0; joy_o = all ones (nothing pressed); frame_o = 0.
  - FSM = SETTLE; settle counter = 0.
  - All debounce candidates = all ones; all debounce counters = 0.
- FSM states:
  - SETTLE: increment the settle counter each enabled clock. When counter == SETTLE_CYCLES, go to SAMPLE. With SETTLE_CYCLES = 0, SETTLE is bypassed and the FSM stays in SAMPLE.
  - SAMPLE (exactly one clock):
    - Capture the slot word from jjoy_i, merged with local_joy_i for slot 0 when LOCAL_MERGE = 1.
    - Apply the debounce update for the current slot.
    - Advance jselect_o on the same edge: NUM_PLAYERS−1 wraps to 0.
    - Clear the settle counter and return to SETTLE.
  - Slot period = SETTLE_CYCLES+1 clocks. Full scan = NUM_PLAYERS*(SETTLE_CYCLES+1) clocks.
- Debounce, per slot, evaluated only on that slot's SAMPLE edge:
  - If sample ≠ candidate: candidate ← sample, count ← 1.
  - Else count ← min(count+1, DEBOUNCE_SAMPLES).
  - When the post-update count == DEBOUNCE_SAMPLES, the slot word in joy_o ← candidate on that same edge.
  - Latency from a stable input to joy_o = DEBOUNCE_SAMPLES slot visits; DEBOUNCE_SAMPLES = 1 gives a one-edge update.
- frame_o: asserted for one clock, registered on the SAMPLE edge of slot NUM_PLAYERS−1, so it is visible in the following cycle. With NUM_PLAYERS = 1 it pulses every slot period.
- NUM_PLAYERS = 1: jselect_o stays 0.
- enable_i low: FSM, counters, jselect_o and joy_o hold; frame_o forced 0. When enable_i returns high, scanning resumes from the exact held state with no extra settle.
- Reset mid-scan: all state returns to reset values on the next edge; a partially debounced change is discarded.
- Simultaneous reset and enable_i: reset wins.
- Counters are sized to hold SETTLE_CYCLES and DEBOUNCE_SAMPLES exactly; no wrap is possible.
- Legacy equivalence: NUM_PLAYERS = 2, SETTLE_CYCLES = 0, DEBOUNCE_SAMPLES = 1 reproduces the old splitter, i.e. select toggles every clock and each player is latched on alternate clocks.

Decomposition:
- Shared package jamma_pkg contains:
  - the FSM state enum (SETTLE, SAMPLE);
  - a clog2 helper function;
  - JAMMA bit-position constants: START = 7, COIN-free word layout, directions 0..3, fire 4..5;
  - JOY_RELEASED = all-ones constant.
- One sub-module, jamma_debounce, holds candidate, count and output register for one slot. It has ports clk, reset, sample_en, din, dout. It is instantiated NUM_PLAYERS times via generate.

Test Plan:
- Reset → jselect_o = 0, joy_o = 16'hFFFF, frame_o = 0. With jjoy_i = 8'h00 held for 3 clocks while reset is high, joy_o stays FFFF.
- Defaults, jjoy_i = 8'hFE only while jselect_o = 1, else FF → jselect_o alternates 0 and 1 every 5 clocks. joy_o[15:8] becomes FE after the 3rd slot-1 sample (about 30 clocks); joy_o[7:0] stays FF. frame_o pulses every 10 clocks.
- Glitch: slot 0 input = 8'h7F for a single sample, then FF → joy_o[7:0] never leaves FF. An input held at 7F for 3 consecutive slot-0 samples → joy_o[7:0] = 7F.
- LOCAL_MERGE = 1, jjoy_i = FF, local_joy_i = 8'hDF → joy_o[7:0] = DF, joy_o[15:8] = FF.
- NUM_PLAYERS = 4, SEL_W = 2, SETTLE_CYCLES = 0, DEBOUNCE_SAMPLES = 1 → jselect_o cycles 0,1,2,3,0 on successive clocks. frame_o is high on every 4th clock, one cycle after the sel = 3 sample.
- enable_i low for 20 clocks mid-SETTLE → jselect_o and joy_o frozen, frame_o = 0. After re-enable, the remaining settle count completes with no restart of the settle period.

Source files
------------

// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA input scanner: scan FSM state,
// a width helper and the active-low player-word bit layout.
package jamma_pkg;

  typedef enum logic {
    StSettle,
    StSample
  } scan_state_e;

  // Player word layout (active-low): directions 0..3, fire 4..5, bit 6 spare, start 7.
  localparam int unsigned DIR_LSB  = 0;
  localparam int unsigned DIR_MSB  = 3;
  localparam int unsigned FIRE_LSB = 4;
  localparam int unsigned FIRE_MSB = 5;
  localparam int unsigned START    = 7;

  localparam logic [7:0] JOY_RELEASED = 8'hFF;

  // Bits needed to index 'value' distinct codes, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// One player slot: a word reaches dout only after DEBOUNCE_SAMPLES identical
// consecutive samples, each sample arriving on a sample_en edge.
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int unsigned JOY_W            = 8,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [JOY_W-1:0] din,
  output logic [JOY_W-1:0] dout
);

  localparam int unsigned CntW = clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_SAMPLES);

  logic [JOY_W-1:0] cand_q;
  logic [JOY_W-1:0] dout_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (din != cand_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // On a match cand_q already equals din, so din is the word to publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q <= '1;
      cnt_q  <= '0;
      dout_q <= '1;
    end else if (sample_en) begin
      cand_q <= din;
      cnt_q  <= cnt_d;
      if (cnt_d == CntMax) dout_q <= din;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/jamma_input_scanner.sv
// Time-multiplexed JAMMA scanner: steps the player select, waits for the bus to
// settle, samples one slot per period and debounces each slot independently.
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS      = 2,
  parameter int unsigned JOY_W            = 8,
  parameter int unsigned SEL_W            = 1,
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SAMPLES = 3,
  parameter int unsigned LOCAL_MERGE      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic [JOY_W-1:0]             jjoy_i,
  input  logic [JOY_W-1:0]             local_joy_i,
  output logic [SEL_W-1:0]             jselect_o,
  output logic [NUM_PLAYERS*JOY_W-1:0] joy_o,
  output logic                         frame_o
);

  localparam int unsigned SetW = clog2(SETTLE_CYCLES + 1);
  localparam logic [SetW-1:0]  SettleMax = SetW'(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] LastSel   = SEL_W'(NUM_PLAYERS - 1);
  // With no settle time the FSM never leaves SAMPLE.
  localparam scan_state_e ResetState = (SETTLE_CYCLES == 0) ? StSample : StSettle;

  scan_state_e      state_q;
  logic [SetW-1:0]  cnt_q;
  logic [SEL_W-1:0] sel_q;
  logic             frame_q;
  logic             sample_now;
  logic [JOY_W-1:0] slot_word;

  assign sample_now = enable_i && (state_q == StSample);

  always_comb begin
    slot_word = jjoy_i;
    if (LOCAL_MERGE != 0 && sel_q == '0) slot_word = jjoy_i & local_joy_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      sel_q   <= '0;
      frame_q <= 1'b0;
    end else if (!enable_i) begin
      frame_q <= 1'b0;
    end else begin
      unique case (state_q)
        StSettle: begin
          frame_q <= 1'b0;
          cnt_q   <= cnt_q + SetW'(1);
          if (cnt_q + SetW'(1) == SettleMax) state_q <= StSample;
        end
        StSample: begin
          frame_q <= (sel_q == LastSel);
          sel_q   <= (sel_q == LastSel) ? '0 : sel_q + SEL_W'(1);
          cnt_q   <= '0;
          if (SETTLE_CYCLES != 0) state_q <= StSettle;
        end
        default: state_q <= ResetState;
      endcase
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_slot
    logic slot_en;
    assign slot_en = sample_now && (sel_q == SEL_W'(p));

    jamma_debounce #(
      .JOY_W           (JOY_W),
      .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .sample_en(slot_en),
      .din      (slot_word),
      .dout     (joy_o[p*JOY_W +: JOY_W])
    );
  end

  assign jselect_o = sel_q;
  // A pulse registered just before a disable is suppressed while disabled.
  assign frame_o   = frame_q & enable_i;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Bench for jamma_input_scanner: a default-configured instance and a 4-player
// legacy-style instance, both compared each cycle against a slot/history model.
module tb_jamma_input_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en;
  logic [7:0]  jjoy_v[2];
  logic [7:0]  loc_v[2];
  logic        sel_a;
  logic [15:0] joy_a;
  logic        frame_a;
  logic [1:0]  sel_b;
  logic [31:0] joy_b;
  logic        frame_b;

  int errors = 0;
  int checks = 0;

  jamma_input_scanner u_dut_a (
    .clk        (clk),
    .reset      (rst),
    .enable_i   (en),
    .jjoy_i     (jjoy_v[0]),
    .local_joy_i(loc_v[0]),
    .jselect_o  (sel_a),
    .joy_o      (joy_a),
    .frame_o    (frame_a)
  );

  jamma_input_scanner #(
    .NUM_PLAYERS     (4),
    .JOY_W           (8),
    .SEL_W           (2),
    .SETTLE_CYCLES   (0),
    .DEBOUNCE_SAMPLES(1),
    .LOCAL_MERGE     (0)
  ) u_dut_b (
    .clk        (clk),
    .reset      (rst),
    .enable_i   (en),
    .jjoy_i     (jjoy_v[1]),
    .local_joy_i(loc_v[1]),
    .jselect_o  (sel_b),
    .joy_o      (joy_b),
    .frame_o    (frame_b)
  );

  // Configuration of instance k: players, settle, debounce, merge.
  function automatic int cfg_n(input int k); return (k == 0) ? 2 : 4; endfunction
  function automatic int cfg_s(input int k); return (k == 0) ? 4 : 0; endfunction
  function automatic int cfg_d(input int k); return (k == 0) ? 3 : 1; endfunction
  function automatic bit cfg_m(input int k); return (k == 0); endfunction

  // Model: enabled clocks since last sample, slot pointer, last three samples per slot.
  int         m_phase[2];
  int         m_sel[2];
  bit         m_frame[2];
  logic [7:0] m_joy[2][4];
  logic [7:0] m_win[2][4][3];
  int         m_fill[2][4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int n, s, d, cur;
    logic [7:0] w;
    bit stable;
    n = cfg_n(k); s = cfg_s(k); d = cfg_d(k);
    if (rst) begin
      m_phase[k] = 0; m_sel[k] = 0; m_frame[k] = 0;
      for (int p = 0; p < 4; p++) begin m_joy[k][p] = 8'hFF; m_fill[k][p] = 0; end
    end else if (!en) begin
      m_frame[k] = 0;
    end else if (m_phase[k] == s) begin
      cur = m_sel[k];
      w = jjoy_v[k] & ((cur == 0 && cfg_m(k)) ? loc_v[k] : 8'hFF);
      for (int j = 2; j > 0; j--) m_win[k][cur][j] = m_win[k][cur][j-1];
      m_win[k][cur][0] = w;
      if (m_fill[k][cur] < 3) m_fill[k][cur]++;
      stable = (m_fill[k][cur] >= d);
      for (int j = 0; j < d; j++) if (m_win[k][cur][j] != w) stable = 0;
      if (stable) m_joy[k][cur] = w;
      m_frame[k] = (cur == n - 1);
      m_sel[k] = (cur + 1) % n;
      m_phase[k] = 0;
    end else begin
      m_phase[k]++;
      m_frame[k] = 0;
    end
  endtask

  function automatic logic [31:0] exp_joy(input int k);
    logic [31:0] r;
    r = '0;
    for (int p = 0; p < cfg_n(k); p++) r[p*8 +: 8] = m_joy[k][p];
    return r;
  endfunction

  function automatic logic [7:0] rand_word();
    case ($urandom_range(4))
      0: return 8'hFF;
      1: return 8'h7F;
      2: return 8'hFE;
      3: return 8'hDF;
      default: return 8'($urandom);
    endcase
  endfunction

  // One clock: update model at the edge, compare at the falling edge, stir instance B.
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check("sel_a", 32'(sel_a), 32'(m_sel[0]));
    check("joy_a", 32'(joy_a), exp_joy(0));
    check("frame_a", 32'(frame_a), 32'(m_frame[0] & en));
    check("sel_b", 32'(sel_b), 32'(m_sel[1]));
    check("joy_b", joy_b, exp_joy(1));
    check("frame_b", 32'(frame_b), 32'(m_frame[1] & en));
    if ($urandom_range(7) == 0) jjoy_v[1] = rand_word();
    loc_v[1] = 8'($urandom);
  endtask

  task automatic wait_sel_a(input logic v);
    for (int i = 0; i < 30 && sel_a !== v; i++) cycle();
    check("wait_sel_a", 32'(sel_a), 32'(v));
  endtask

  initial begin
    int nfr, waited, s0;
    logic       hold_sel;
    logic [15:0] hold_joy;

    rst = 1'b1; en = 1'b1;
    jjoy_v[0] = 8'h00; jjoy_v[1] = 8'h00;
    loc_v[0]  = 8'hFF; loc_v[1]  = 8'hFF;
    repeat (3) cycle();
    check("reset_joy_a", 32'(joy_a), 32'h0000FFFF);
    check("reset_sel_a", 32'(sel_a), 32'h0);
    check("reset_frame_a", 32'(frame_a), 32'h0);
    check("reset_joy_b", joy_b, 32'hFFFFFFFF);

    // Player 1 pressing bit 0; only visible while slot 1 is selected.
    rst = 1'b0;
    jjoy_v[0] = 8'hFF;
    nfr = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (frame_a) nfr++;
      jjoy_v[0] = sel_a ? 8'hFE : 8'hFF;
    end
    check("p1_word", 32'(joy_a[15:8]), 32'hFE);
    check("p0_idle", 32'(joy_a[7:0]), 32'hFF);
    check("frame_count", 32'(nfr), 32'd4);

    // Single-sample glitch on slot 0 must be rejected.
    jjoy_v[0] = 8'hFF;
    wait_sel_a(1'b1);
    wait_sel_a(1'b0);
    jjoy_v[0] = 8'h7F;
    wait_sel_a(1'b1);
    jjoy_v[0] = 8'hFF;
    repeat (40) cycle();
    check("glitch_lo", 32'(joy_a[7:0]), 32'hFF);
    jjoy_v[0] = 8'h7F;
    repeat (35) cycle();
    check("hold_lo", 32'(joy_a[7:0]), 32'h7F);

    // Local joystick folded into player 0 only.
    jjoy_v[0] = 8'hFF;
    loc_v[0]  = 8'hDF;
    repeat (40) cycle();
    check("merge", 32'(joy_a), 32'h0000FFDF);
    loc_v[0] = 8'hFF;

    // Freeze two clocks into a settle period; three enabled edges must remain.
    s0 = sel_a;
    for (int i = 0; i < 20 && sel_a == s0[0]; i++) cycle();
    repeat (2) cycle();
    hold_sel = sel_a; hold_joy = joy_a;
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("frozen_sel", 32'(sel_a), 32'(hold_sel));
      check("frozen_joy", 32'(joy_a), 32'(hold_joy));
      check("frozen_frame", 32'(frame_a), 32'h0);
    end
    en = 1'b1;
    waited = 0;
    for (int i = 0; i < 10 && sel_a == hold_sel; i++) begin cycle(); waited++; end
    check("resume_settle", 32'(waited), 32'd3);

    // Legacy-style instance: select walks every clock, frame follows slot 3.
    s0 = sel_b;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check("legacy_sel", 32'(sel_b), 32'((s0 + i) % 4));
      check("legacy_frame", 32'(frame_b), 32'(((s0 + i) % 4) == 0));
    end

    // Randomized traffic with dropouts and occasional mid-scan resets.
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(15) != 0);
      rst = ($urandom_range(249) == 0);
      if ($urandom_range(11) == 0) jjoy_v[0] = rand_word();
      if ($urandom_range(29) == 0) loc_v[0] = ($urandom_range(1) == 0) ? 8'hFF : rand_word();
      cycle();
    end
    rst = 1'b0; en = 1'b1;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
